// File: rtl/gs_audio_pkg.sv
// Shared definitions for the General Sound audio output stages.
package gs_audio_pkg;

    localparam int unsigned I2S_SLOT_BITS  = 16;
    localparam int unsigned I2S_FRAME_BITS = 32;

    typedef struct packed {
        logic [I2S_SLOT_BITS-1:0] left;
        logic [I2S_SLOT_BITS-1:0] right;
    } i2s_frame_t;

    // Unsigned sample (midpoint 2^(width-1)) to left-aligned signed 16-bit.
    // Left-aligning first puts the source MSB at bit 15, where inverting it
    // subtracts the midpoint. Valid for width <= 16.
    function automatic logic [I2S_SLOT_BITS-1:0] to_s16(input logic [15:0] x,
                                                        input int unsigned width);
        logic [15:0] aligned;
        aligned = x << (16 - width);
        return {~aligned[15], aligned[14:0]};
    endfunction

endpackage

// File: rtl/gs_i2s_clkgen.sv
// Bit-clock divider: fixed 50% duty BCLK from clk_sys plus a falling-event strobe.
module gs_i2s_clkgen #(
    parameter int unsigned DIV = 8
) (
    input  logic clk_sys,
    input  logic reset,
    output logic bclk,
    output logic fall_c
);

    localparam int unsigned CNT_W = (DIV > 0) ? $clog2(DIV + 1) : 1;

    logic [CNT_W-1:0] div_cnt;
    logic             div_hit_c;

    assign div_hit_c = (div_cnt == CNT_W'(DIV));
    // The toggle that takes BCLK from 1 to 0 is the event the serialiser runs on.
    assign fall_c    = div_hit_c & bclk;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (div_hit_c) begin
            div_cnt <= '0;
            bclk    <= ~bclk;
        end else begin
            div_cnt <= div_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/gs_i2s_tx.sv
// General Sound output stage: re-centres the L/R channel sums and serialises
// them as a Philips I2S stream (one-BCLK delay, MSB first).
module gs_i2s_tx
    import gs_audio_pkg::*;
#(
    parameter int unsigned DIV  = 8,
    parameter int unsigned IN_W = 9
) (
    input  logic            clk_sys,
    input  logic            reset,
    input  logic [IN_W-1:0] in_l,
    input  logic [IN_W-1:0] in_r,
    input  logic            mute,
    output logic            i2s_bclk,
    output logic            i2s_lrck,
    output logic            i2s_data,
    output logic            sample_strobe
);

    localparam int unsigned BIT_W = $clog2(I2S_FRAME_BITS);

    logic                      fall_c;
    logic [BIT_W-1:0]          bit_cnt;
    logic [BIT_W-1:0]          bit_nxt_c;
    logic [I2S_FRAME_BITS-1:0] shreg;
    i2s_frame_t                frame_c;

    gs_i2s_clkgen #(
        .DIV (DIV)
    ) u_clkgen (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bclk    (i2s_bclk),
        .fall_c  (fall_c)
    );

    assign bit_nxt_c = bit_cnt + BIT_W'(1);

    // Word loaded at slot 0; mute is only looked at here so a frame never tears.
    always_comb begin
        frame_c = '0;
        if (!mute) begin
            frame_c.left  = to_s16(16'(in_l), IN_W);
            frame_c.right = to_s16(16'(in_r), IN_W);
        end
    end

    // Serialiser: data shifts out of bit 31 one fall after the load, which
    // yields the standard one-BCLK I2S delay relative to LRCK.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            bit_cnt       <= '1;
            i2s_lrck      <= 1'b1;
            i2s_data      <= 1'b0;
            shreg         <= '0;
            sample_strobe <= 1'b0;
        end else begin
            sample_strobe <= 1'b0;
            if (fall_c) begin
                bit_cnt  <= bit_nxt_c;
                i2s_lrck <= (bit_nxt_c >= BIT_W'(I2S_SLOT_BITS));
                i2s_data <= shreg[I2S_FRAME_BITS-1];
                if (bit_nxt_c == '0) begin
                    shreg         <= frame_c;
                    sample_strobe <= 1'b1;
                end else begin
                    shreg <= {shreg[I2S_FRAME_BITS-2:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: tb/tb_gs_i2s_tx.sv
// Directed bench for gs_i2s_tx: reset/start-up timing, frame content, mute and
// mid-frame reset, with frames decoded from the serial pins.
module tb_gs_i2s_tx;

    logic       clk_sys = 1'b0;
    logic       reset;
    logic [8:0] in_l, in_r;
    logic       mute;
    logic       i2s_bclk, i2s_lrck, i2s_data, sample_strobe;

    int errors = 0;
    int checks = 0;

    gs_i2s_tx #(.DIV(8), .IN_W(9)) dut (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .in_l          (in_l),
        .in_r          (in_r),
        .mute          (mute),
        .i2s_bclk      (i2s_bclk),
        .i2s_lrck      (i2s_lrck),
        .i2s_data      (i2s_data),
        .sample_strobe (sample_strobe)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Receiver model: sample data on BCLK rising; a frame is complete on the
    // first rising with LRCK low, which carries R[0] of the previous frame.
    logic [31:0] frame_sr   = '0;
    logic [31:0] last_frame = '0;
    logic        prev_bclk  = 1'b0;
    logic        prev_lrck  = 1'b1;
    int          cyc = 0, strobe_cnt = 0, last_strobe_cyc = 0, strobe_gap = 0;

    always @(negedge clk_sys) begin
        cyc = cyc + 1;
        if (i2s_bclk && !prev_bclk) begin
            frame_sr = {frame_sr[30:0], i2s_data};
            if (!i2s_lrck && prev_lrck) last_frame = frame_sr;
            prev_lrck = i2s_lrck;
        end
        prev_bclk = i2s_bclk;
        if (sample_strobe) begin
            strobe_gap      = cyc - last_strobe_cyc;
            last_strobe_cyc = cyc;
            strobe_cnt      = strobe_cnt + 1;
        end
    end

    task automatic wait_strobe(input string tag);
        int start;
        bit seen;
        start = strobe_cnt;
        seen  = 1'b0;
        for (int i = 0; i < 1200 && !seen; i++) begin
            @(negedge clk_sys); #1;
            if (strobe_cnt != start) seen = 1'b1;
        end
        check({tag, "_strobe_timeout"}, 32'(seen), 32'd1);
    endtask

    // Returns the frame that was loaded at the strobe before the next one.
    task automatic next_frame(input string tag, input logic [31:0] exp, input bit gap_chk);
        wait_strobe(tag);
        if (gap_chk) check({tag, "_gap"}, 32'(strobe_gap), 32'd576);
        repeat (12) @(negedge clk_sys);
        #1;
        check({tag, "_frame"}, last_frame, exp);
    endtask

    // Release reset at a negedge and check start-up timing of the first frame.
    task automatic release_check(input string tag);
        int first;
        first = 0;
        reset = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk_sys);
            if (sample_strobe && first == 0) first = i;
            if (i == 8)  check({tag, "_bclk8"},  32'(i2s_bclk), 32'd0);
            if (i == 9)  check({tag, "_bclk9"},  32'(i2s_bclk), 32'd1);
            if (i == 17) check({tag, "_lrck17"}, 32'(i2s_lrck), 32'd1);
            if (i == 18) begin
                check({tag, "_bclk18"}, 32'(i2s_bclk), 32'd0);
                check({tag, "_lrck18"}, 32'(i2s_lrck), 32'd0);
            end
            if (i == 20) check({tag, "_data_slot0"}, 32'(i2s_data), 32'd0);
        end
        check({tag, "_first_strobe"}, 32'(first), 32'd18);
    endtask

    task automatic reset_values(input string tag);
        check({tag, "_bclk"},   32'(i2s_bclk),      32'd0);
        check({tag, "_lrck"},   32'(i2s_lrck),      32'd1);
        check({tag, "_data"},   32'(i2s_data),      32'd0);
        check({tag, "_strobe"}, 32'(sample_strobe), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        in_l  = 9'd510;
        in_r  = 9'd0;
        mute  = 1'b0;
        repeat (3) @(negedge clk_sys);
        reset_values("rst");
        release_check("start");

        // Frame 1 was loaded with 510/0; feed the mid-scale pair next.
        in_l = 9'd256;
        in_r = 9'd256;
        next_frame("full_scale", 32'h7F00_8000, 1'b1);

        in_l = 9'd100;
        next_frame("mid_scale", 32'h0000_0000, 1'b1);

        // Change at ~n=8: the frame holding 100 (-156 -> B200) must not change.
        repeat (132) @(negedge clk_sys);
        in_l = 9'd400;
        next_frame("in_l_100", 32'hB200_0000, 1'b1);

        in_l = 9'd510;
        next_frame("in_l_400", 32'h4800_0000, 1'b1);

        // Mute at ~n=20 leaves the current frame (510) intact.
        repeat (348) @(negedge clk_sys);
        mute = 1'b1;
        next_frame("pre_mute", 32'h7F00_0000, 1'b1);
        mute = 1'b0;
        next_frame("muted", 32'h0000_0000, 1'b1);
        next_frame("unmuted", 32'h7F00_0000, 1'b1);

        // One-cycle reset around n=10, then a clean restart.
        repeat (170) @(negedge clk_sys);
        #1 reset = 1'b1;
        @(negedge clk_sys);
        reset_values("mid_rst");
        release_check("restart");
        next_frame("restart", 32'h7F00_0000, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
